// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment and sign extension, jal link write,
// misaligned-load detection and a retired-instruction counter.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_reg_write,
  input  logic             in_mem_to_reg,
  input  logic             in_jal,
  input  logic [4:0]       in_dest,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_mem_rdata,
  input  logic [2:0]       in_load_type,
  input  logic [31:0]      in_link_addr,
  output logic             wb_reg_write,
  output logic [4:0]       wb_dest,
  output logic [31:0]      wb_data,
  output logic             wb_jal_write,
  output logic [31:0]      wb_ra_data,
  output logic             wb_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retire_count
);

  // Stage control: flush beats stall; stall holds everything; otherwise capture every edge.
  logic        valid_q, reg_write_q, mem_to_reg_q, jal_q, reported_q;
  logic [4:0]  dest_q;
  logic [31:0] alu_q, rdata_q, link_q;
  logic [2:0]  load_type_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      jal_q        <= 1'b0;
      dest_q       <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
      load_type_q  <= '0;
      link_q       <= '0;
      reported_q   <= 1'b0;
      count_q      <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      reported_q <= 1'b0;
    end else if (!stall) begin
      valid_q      <= in_valid;
      reg_write_q  <= in_reg_write;
      mem_to_reg_q <= in_mem_to_reg;
      jal_q        <= in_jal;
      dest_q       <= in_dest;
      alu_q        <= in_alu_result;
      rdata_q      <= in_mem_rdata;
      load_type_q  <= in_load_type;
      link_q       <= in_link_addr;
      reported_q   <= 1'b0;
      if (in_valid) count_q <= count_q + CNT_W'(1);
    end else begin
      // Remember that the error was already signalled so a held instruction pulses once.
      reported_q <= reported_q | misalign_err;
    end
  end

  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        misaligned;

  always_comb begin
    off        = alu_q[1:0];
    byte_sel   = rdata_q[7:0];
    half_sel   = off[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_data  = rdata_q;
    misaligned = 1'b0;
    case (off)
      2'd0: byte_sel = rdata_q[7:0];
      2'd1: byte_sel = rdata_q[15:8];
      2'd2: byte_sel = rdata_q[23:16];
      2'd3: byte_sel = rdata_q[31:24];
      default: byte_sel = rdata_q[7:0];
    endcase
    case (load_type_q)
      3'd1: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd2: load_data = {24'd0, byte_sel};
      3'd3: begin
        load_data  = {{16{half_sel[15]}}, half_sel};
        misaligned = off[0];
      end
      3'd4: begin
        load_data  = {16'd0, half_sel};
        misaligned = off[0];
      end
      default: begin
        load_data  = rdata_q;
        misaligned = (off != 2'd0);
      end
    endcase
  end

  assign wb_data      = mem_to_reg_q ? load_data : alu_q;
  assign wb_dest      = dest_q;
  assign wb_reg_write = valid_q & reg_write_q & ~jal_q & (dest_q != 5'd0)
                        & ~(mem_to_reg_q & misaligned);
  assign wb_jal_write = valid_q & jal_q;
  assign wb_ra_data   = link_q;
  assign wb_valid     = valid_q;
  assign misalign_err = valid_q & mem_to_reg_q & misaligned & ~reported_q;
  assign retire_count = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; a second CNT_W=4 instance shares the inputs for counter wrap.
module tb_mem_wb_stage;
  logic        clk, reset, stall, flush;
  logic        in_valid, in_reg_write, in_mem_to_reg, in_jal;
  logic [4:0]  in_dest;
  logic [31:0] in_alu_result, in_mem_rdata, in_link_addr;
  logic [2:0]  in_load_type;
  logic        wb_reg_write, wb_jal_write, wb_valid, misalign_err;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data, wb_ra_data, retire_count;
  logic        s_reg_write, s_jal_write, s_valid, s_misalign_err;
  logic [4:0]  s_dest;
  logic [31:0] s_data, s_ra_data;
  logic [3:0]  s_count;
  int vectors = 0;
  int errors  = 0;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_jal(in_jal),
    .in_dest(in_dest), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_load_type(in_load_type), .in_link_addr(in_link_addr),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
    .wb_jal_write(wb_jal_write), .wb_ra_data(wb_ra_data), .wb_valid(wb_valid),
    .misalign_err(misalign_err), .retire_count(retire_count)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_jal(in_jal),
    .in_dest(in_dest), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_load_type(in_load_type), .in_link_addr(in_link_addr),
    .wb_reg_write(s_reg_write), .wb_dest(s_dest), .wb_data(s_data),
    .wb_jal_write(s_jal_write), .wb_ra_data(s_ra_data), .wb_valid(s_valid),
    .misalign_err(s_misalign_err), .retire_count(s_count)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after a rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0; in_jal = 0;
    in_dest = 0; in_alu_result = 0; in_mem_rdata = 0; in_load_type = 0; in_link_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic jal, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [2:0] lt,
                       input logic [31:0] link);
    in_valid = 1; in_reg_write = rw; in_mem_to_reg = m2r; in_jal = jal; in_dest = dest;
    in_alu_result = alu; in_mem_rdata = rdata; in_load_type = lt; in_link_addr = link;
  endtask

  task automatic test_reset();
    idle_inputs();
    drive(1, 0, 1, 5'd9, 32'h1111_2222, 32'h3333_4444, 3'd0, 32'h5555_6666);
    reset = 1;
    step();
    vectors++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", wb_valid); end
    vectors++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %0b exp 0", wb_reg_write); end
    vectors++; if (wb_jal_write !== 1'b0) begin errors++; $display("FAIL reset_jal_write got %0b exp 0", wb_jal_write); end
    vectors++; if (retire_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", retire_count); end
    vectors++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", wb_data); end
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_byte_loads();
    do_reset();
    drive(1, 1, 0, 5'd5, 32'h0000_1003, 32'h80FF_1234, 3'd1, 32'd0);
    step();
    vectors++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL lb_reg_write got %0b exp 1", wb_reg_write); end
    vectors++; if (wb_dest !== 5'd5) begin errors++; $display("FAIL lb_dest got %0d exp 5", wb_dest); end
    vectors++; if (wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", wb_data); end
    vectors++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL lb_misalign got %0b exp 0", misalign_err); end
    vectors++; if (retire_count !== 32'd1) begin errors++; $display("FAIL lb_count got %0d exp 1", retire_count); end
    drive(1, 1, 0, 5'd6, 32'h0000_1003, 32'h80FF_1234, 3'd2, 32'd0);
    step();
    vectors++; if (wb_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", wb_data); end
    drive(1, 1, 0, 5'd6, 32'h0000_1001, 32'h80FF_1234, 3'd1, 32'd0);
    step();
    vectors++; if (wb_data !== 32'h0000_0012) begin errors++; $display("FAIL lb_off1_data got %h exp 00000012", wb_data); end
    idle_inputs();
  endtask

  task automatic test_half_word_loads();
    do_reset();
    drive(1, 1, 0, 5'd8, 32'h0000_2002, 32'h9ABC_0000, 3'd4, 32'd0);
    step();
    vectors++; if (wb_data !== 32'h0000_9ABC) begin errors++; $display("FAIL lhu_data got %h exp 00009abc", wb_data); end
    vectors++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL lhu_reg_write got %0b exp 1", wb_reg_write); end
    drive(1, 1, 0, 5'd8, 32'h0000_2000, 32'h0000_8001, 3'd3, 32'd0);
    step();
    vectors++; if (wb_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data got %h exp ffff8001", wb_data); end
    drive(1, 1, 0, 5'd8, 32'h0000_2000, 32'hCAFE_F00D, 3'd6, 32'd0);
    step();
    vectors++; if (wb_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL lw_type6_data got %h exp cafef00d", wb_data); end
    // Misaligned LH: error pulses once and stays low while the instruction is held.
    drive(1, 1, 0, 5'd8, 32'h0000_2001, 32'h9ABC_0000, 3'd3, 32'd0);
    step();
    vectors++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL lh_mis_reg_write got %0b exp 0", wb_reg_write); end
    vectors++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL lh_mis_err1 got %0b exp 1", misalign_err); end
    stall = 1;
    step();
    vectors++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL lh_mis_err2 got %0b exp 0", misalign_err); end
    vectors++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lh_mis_held_valid got %0b exp 1", wb_valid); end
    stall = 0;
    drive(1, 1, 0, 5'd8, 32'h0000_2002, 32'h9ABC_0000, 3'd0, 32'd0);
    step();
    vectors++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL lw_mis_err got %0b exp 1", misalign_err); end
    vectors++; if (retire_count !== 32'd5) begin errors++; $display("FAIL hw_count got %0d exp 5", retire_count); end
    idle_inputs();
  endtask

  task automatic test_jal();
    do_reset();
    drive(1, 0, 1, 5'd31, 32'h0000_0044, 32'd0, 3'd0, 32'h0040_0008);
    step();
    vectors++; if (wb_jal_write !== 1'b1) begin errors++; $display("FAIL jal_write got %0b exp 1", wb_jal_write); end
    vectors++; if (wb_ra_data !== 32'h0040_0008) begin errors++; $display("FAIL jal_ra got %h exp 00400008", wb_ra_data); end
    vectors++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL jal_reg_write got %0b exp 0", wb_reg_write); end
    idle_inputs();
    step();
    vectors++; if (wb_jal_write !== 1'b0) begin errors++; $display("FAIL jal_bubble got %0b exp 0", wb_jal_write); end
  endtask

  task automatic test_dest_zero();
    do_reset();
    drive(1, 0, 0, 5'd0, 32'h0000_1234, 32'd0, 3'd0, 32'd0);
    step();
    vectors++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL d0_reg_write got %0b exp 0", wb_reg_write); end
    vectors++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL d0_valid got %0b exp 1", wb_valid); end
    vectors++; if (retire_count !== 32'd1) begin errors++; $display("FAIL d0_count got %0d exp 1", retire_count); end
    vectors++; if (wb_data !== 32'h0000_1234) begin errors++; $display("FAIL d0_data got %h exp 00001234", wb_data); end
    idle_inputs();
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive(1, 0, 0, 5'd7, 32'hAAAA_5555, 32'd0, 3'd0, 32'd0);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 5'(i + 10), 32'h1000 + i, 32'hFFFF_FFFF, 3'd1, 32'h77);
      step();
      vectors++; if (wb_data !== 32'hAAAA_5555) begin errors++; $display("FAIL stall_data[%0d] got %h exp aaaa5555", i, wb_data); end
      vectors++; if (wb_dest !== 5'd7) begin errors++; $display("FAIL stall_dest[%0d] got %0d exp 7", i, wb_dest); end
      vectors++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL stall_reg_write[%0d] got %0b exp 1", i, wb_reg_write); end
      vectors++; if (retire_count !== 32'd1) begin errors++; $display("FAIL stall_count[%0d] got %0d exp 1", i, retire_count); end
    end
    flush = 1;
    step();
    vectors++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", wb_valid); end
    vectors++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL flush_reg_write got %0b exp 0", wb_reg_write); end
    vectors++; if (retire_count !== 32'd1) begin errors++; $display("FAIL flush_count got %0d exp 1", retire_count); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1, 0, 0, 5'd3, 32'd1, 32'd0, 3'd0, 32'd0);
    for (int i = 0; i < 15; i++) step();
    vectors++; if (s_count !== 4'd15) begin errors++; $display("FAIL wrap_pre got %0d exp 15", s_count); end
    step();
    vectors++; if (s_count !== 4'd0) begin errors++; $display("FAIL wrap_post got %0d exp 0", s_count); end
    vectors++; if (retire_count !== 32'd16) begin errors++; $display("FAIL wide_count got %0d exp 16", retire_count); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 1, 0, 5'd4, 32'h0000_0001, 32'h1234_5678, 3'd0, 32'h0000_0010);
    step();
    drive(1, 0, 1, 5'd31, 32'd0, 32'd0, 3'd0, 32'h0040_0000);
    step();
    stall = 1;
    #2;
    reset = 1;
    #1;
    vectors++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b exp 0", wb_valid); end
    vectors++; if (wb_jal_write !== 1'b0) begin errors++; $display("FAIL areset_jal got %0b exp 0", wb_jal_write); end
    vectors++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL areset_reg_write got %0b exp 0", wb_reg_write); end
    vectors++; if (wb_ra_data !== 32'd0) begin errors++; $display("FAIL areset_ra got %h exp 0", wb_ra_data); end
    vectors++; if (retire_count !== 32'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", retire_count); end
    vectors++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL areset_misalign got %0b exp 0", misalign_err); end
    step();
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_byte_loads();
    test_half_word_loads();
    test_jal();
    test_dest_zero();
    test_stall_flush();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
